// File: rtl/mult_operand_loader_if.sv
// Handshake bundle between the operand loader (master) and the sequential multiplier (slave).
interface mult_operand_loader_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  modport master (
    output mul_a,
    output mul_b,
    output mul_start,
    input  mul_done,
    input  mul_product
  );

  modport slave (
    input  mul_a,
    input  mul_b,
    input  mul_start,
    output mul_done,
    output mul_product
  );
endinterface

// File: rtl/mult_operand_loader.sv
// Operand loader in front of the sequential multiplier: sync, debounce GO, start, wait with timeout, capture.
// Optional product self-check enabled by defining MULT_LOADER_CHECK_EN (adds o_check_err).
module mult_operand_loader #(
  parameter int WIDTH        = 3,
  parameter int DEB_CYCLES   = 16,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_sw_a,
  input  logic [WIDTH-1:0]      i_sw_b,
  input  logic                  i_btn,
  mult_operand_loader_if.master mulBus,
  output logic [2*WIDTH-1:0]    o_result,
  output logic                  o_result_valid,
  output logic                  o_busy,
`ifdef MULT_LOADER_CHECK_EN
  output logic                  o_check_err,
`endif
  output logic                  o_timeout_err
);

  localparam int PW  = 2 * WIDTH;
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int SCW = $clog2(START_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE
  } stateT;

  stateT            r_state;
  stateT            w_nextState;
  logic [1:0]       r_btnSync;
  logic [WIDTH-1:0] r_swAMeta;
  logic [WIDTH-1:0] r_swASync;
  logic [WIDTH-1:0] r_swBMeta;
  logic [WIDTH-1:0] r_swBSync;
  logic             r_btnDeb;
  logic             r_btnDebPrev;
  logic [DCW-1:0]   r_debCount;
  logic [SCW-1:0]   r_startCount;
  logic [TCW-1:0]   r_waitCount;
  logic             r_donePrev;
  logic             r_mulStart;
  logic [WIDTH-1:0] r_mulA;
  logic [WIDTH-1:0] r_mulB;
  logic [PW-1:0]    r_result;
  logic             r_resultValid;
  logic             r_timeoutErr;
  logic             w_go;
  logic             w_startLast;
  logic             w_doneRise;
  logic             w_timeoutHit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btnSync <= '0;
      r_swAMeta <= '0;
      r_swASync <= '0;
      r_swBMeta <= '0;
      r_swBSync <= '0;
    end else begin
      r_btnSync <= {r_btnSync[0], i_btn};
      r_swAMeta <= i_sw_a;
      r_swASync <= r_swAMeta;
      r_swBMeta <= i_sw_b;
      r_swBSync <= r_swBMeta;
    end
  end

  // Any cycle where the synced button agrees with the debounced level restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btnDeb     <= 1'b0;
      r_btnDebPrev <= 1'b0;
      r_debCount   <= '0;
    end else begin
      r_btnDebPrev <= r_btnDeb;
      if (r_btnSync[1] == r_btnDeb) begin
        r_debCount <= '0;
      end else if (r_debCount == DCW'(DEB_CYCLES - 1)) begin
        r_btnDeb   <= r_btnSync[1];
        r_debCount <= '0;
      end else begin
        r_debCount <= r_debCount + DCW'(1);
      end
    end
  end

  assign w_go         = r_btnDeb & ~r_btnDebPrev;
  assign w_startLast  = (r_startCount == SCW'(START_CYCLES - 1));
  assign w_doneRise   = mulBus.mul_done & ~r_donePrev;
  assign w_timeoutHit = (r_waitCount == TCW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_go) w_nextState = S_LOAD;
      S_LOAD:    w_nextState = S_START;
      S_START:   if (w_startLast) w_nextState = S_WAIT;
      S_WAIT: begin
        if (w_doneRise) begin
          w_nextState = S_CAPTURE;
        end else if (w_timeoutHit) begin
          w_nextState = S_IDLE;
        end
      end
      S_CAPTURE: w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

`ifdef MULT_LOADER_CHECK_EN
  logic [PW-1:0] w_expProduct;
  logic          r_checkErr;
  assign w_expProduct = PW'(r_mulA) * PW'(r_mulB);
  assign o_check_err  = r_checkErr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_checkErr <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_checkErr <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_checkErr <= (mulBus.mul_product != w_expProduct);
    end
  end
`endif

  // Outside WAIT the done history is primed high, so a done left over from the previous op must drop first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mulStart    <= 1'b0;
      r_startCount  <= '0;
      r_waitCount   <= '0;
      r_donePrev    <= 1'b0;
      r_mulA        <= '0;
      r_mulB        <= '0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
      r_timeoutErr  <= 1'b0;
    end else begin
      r_mulStart   <= (w_nextState == S_START);
      r_startCount <= (r_state == S_START && !w_startLast) ? r_startCount + SCW'(1) : '0;
      r_waitCount  <= (r_state == S_WAIT) ? r_waitCount + TCW'(1) : '0;
      r_donePrev   <= (r_state == S_WAIT) ? mulBus.mul_done : 1'b1;
      case (r_state)
        S_LOAD: begin
          r_mulA        <= r_swASync;
          r_mulB        <= r_swBSync;
          r_resultValid <= 1'b0;
          r_timeoutErr  <= 1'b0;
        end
        S_WAIT: begin
          if (!w_doneRise && w_timeoutHit) r_timeoutErr <= 1'b1;
        end
        S_CAPTURE: begin
          r_result      <= mulBus.mul_product;
          r_resultValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mulBus.mul_a     = r_mulA;
  assign mulBus.mul_b     = r_mulB;
  assign mulBus.mul_start = r_mulStart;
  assign o_result         = r_result;
  assign o_result_valid   = r_resultValid;
  assign o_timeout_err    = r_timeoutErr;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_operand_loader.sv
// Bench for mult_operand_loader: table of button-driven operations against a behavioural multiplier,
// plus a hand-written reset-during-WAIT sequence.
module tb_mult_operand_loader;

  localparam int WIDTH        = 3;
  localparam int START_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] swA;
  logic [2:0] swB;
  logic       btn;
  logic [5:0] result;
  logic       resultValid;
  logic       busy;
  logic       timeoutErr;
`ifdef MULT_LOADER_CHECK_EN
  logic       checkErr;
`endif

  logic       tbDone    = 1'b0;
  logic [5:0] tbProduct = '0;

  mult_operand_loader_if #(.WIDTH(WIDTH)) mulBus ();
  assign mulBus.mul_done    = tbDone;
  assign mulBus.mul_product = tbProduct;

  mult_operand_loader dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sw_a         (swA),
    .i_sw_b         (swB),
    .i_btn          (btn),
    .mulBus         (mulBus),
    .o_result       (result),
    .o_result_valid (resultValid),
    .o_busy         (busy),
`ifdef MULT_LOADER_CHECK_EN
    .o_check_err    (checkErr),
`endif
    .o_timeout_err  (timeoutErr)
  );

  always #5 clk = ~clk;

  // Multiplier model: old done is held for modelHold cycles after start, low for modelDelay, then rises.
  int         modelDelay      = 0;
  int         modelHold       = 0;
  bit         modelNever      = 1'b0;
  bit         modelOverride   = 1'b0;
  logic [5:0] modelOvProduct  = '0;
  int         startEvents     = 0;
  int         startHighCycles = 0;
  logic       startPrevTb     = 1'b0;
  logic [2:0] seenA           = '0;
  logic [2:0] seenB           = '0;
  int         holdLeft        = 0;
  int         delayLeft       = 0;
  bit         active          = 1'b0;

  always @(negedge clk) begin
    if (mulBus.mul_start === 1'b1) startHighCycles++;
    if (mulBus.mul_start === 1'b1 && startPrevTb !== 1'b1) begin
      startEvents++;
      seenA     = mulBus.mul_a;
      seenB     = mulBus.mul_b;
      holdLeft  = modelHold;
      delayLeft = modelDelay;
      active    = 1'b1;
    end else if (active) begin
      if (holdLeft > 0) begin
        holdLeft--;
      end else if (delayLeft > 0) begin
        tbDone = 1'b0;
        delayLeft--;
      end else begin
        if (!modelNever) begin
          tbDone    = 1'b1;
          tbProduct = modelOverride ? modelOvProduct : 6'(int'(seenA) * int'(seenB));
        end
        active = 1'b0;
      end
    end
    startPrevTb = mulBus.mul_start;
  end

  typedef struct {
    int         pattern;
    logic [2:0] a;
    logic [2:0] b;
    int         delay;
    int         hold;
    bit         never;
    bit         override;
    logic [5:0] ovProd;
    logic [5:0] expResult;
    bit         expValid;
    bit         expTimeout;
    bit         expCheck;
  } vecT;

  typedef struct {
    logic [5:0] result;
    bit         valid;
    bit         timeoutErr;
    bit         check;
    logic [2:0] a;
    logic [2:0] b;
  } expT;

  vecT vectors[10];
  expT sbQueue[$];
  int  numCompares    = 0;
  int  numMiscompares = 0;
  int  vectorsApplied = 0;
  int  opEvents;
  int  opWidth;

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    numCompares++;
    if (act !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0: clean press, 1: bouncy press, 2: clean press plus a second press while the op is running.
  function automatic logic btnLevel(input int p, input int i);
    case (p)
      0:       return logic'(i < 25);
      1:       return (i < 30) ? logic'(((i / 3) % 2) == 0) : logic'(i < 60);
      default: return logic'((i < 25) || (i >= 45 && i < 70));
    endcase
  endfunction

  task automatic applyStimulus(input vecT v, input int idx);
    expT e;
    int  ev0;
    int  hi0;
    int  quiet;
    bit  sawBusy;
    bit  finished;
    modelDelay     = v.delay;
    modelHold      = v.hold;
    modelNever     = v.never;
    modelOverride  = v.override;
    modelOvProduct = v.ovProd;
    e.result       = v.expResult;
    e.valid        = v.expValid;
    e.timeoutErr   = v.expTimeout;
    e.check        = v.expCheck;
    e.a            = v.a;
    e.b            = v.b;
    sbQueue.push_back(e);
    ev0      = startEvents;
    hi0      = startHighCycles;
    quiet    = (v.pattern == 0) ? 50 : (v.pattern == 1) ? 85 : 95;
    swA      = v.a;
    swB      = v.b;
    sawBusy  = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      @(negedge clk);
      btn = btnLevel(v.pattern, i);
      if (i == quiet - 10) begin
        swA = ~v.a;
        swB = ~v.b;
      end
      if (busy) sawBusy = 1'b1;
      if (i >= quiet && sawBusy && !busy) finished = 1'b1;
    end
    if (!finished) begin
      numCompares++;
      numMiscompares++;
      $display("[TB] FAIL v%0d completion: busy=%0b sawBusy=%0b, required op to finish", idx, busy, sawBusy);
    end
    opEvents = startEvents - ev0;
    opWidth  = startHighCycles - hi0;
    vectorsApplied++;
  endtask

  task automatic checkOutput(input int idx);
    expT e;
    if (sbQueue.size() == 0) begin
      numCompares++;
      numMiscompares++;
      $display("[TB] FAIL v%0d scoreboard: got empty queue, required one entry", idx);
    end else begin
      e = sbQueue.pop_front();
      expectEq($sformatf("v%0d result", idx), 32'(result), 32'(e.result));
      expectEq($sformatf("v%0d result_valid", idx), 32'(resultValid), 32'(e.valid));
      expectEq($sformatf("v%0d timeout_err", idx), 32'(timeoutErr), 32'(e.timeoutErr));
      expectEq($sformatf("v%0d busy", idx), 32'(busy), 32'd0);
      expectEq($sformatf("v%0d mul_a", idx), 32'(mulBus.mul_a), 32'(e.a));
      expectEq($sformatf("v%0d mul_b", idx), 32'(mulBus.mul_b), 32'(e.b));
      expectEq($sformatf("v%0d start_count", idx), 32'(opEvents), 32'd1);
      expectEq($sformatf("v%0d start_width", idx), 32'(opWidth), 32'(START_CYCLES));
`ifdef MULT_LOADER_CHECK_EN
      expectEq($sformatf("v%0d check_err", idx), 32'(checkErr), 32'(e.check));
`endif
    end
  endtask

  initial begin
    int  ev0;
    bit  sawStart;
    int  fallCount;
    bit  reached;

    rst = 1'b1;
    btn = 1'b0;
    swA = '0;
    swB = '0;

    //                pat a     b     dly hold nev   ovr   ovProd expRes vld   tmo   chk
    vectors[0] = '{0, 3'd5, 3'd3, 10, 0, 1'b0, 1'b0, 6'd0,  6'd15, 1'b1, 1'b0, 1'b0};
    vectors[1] = '{1, 3'd2, 3'd3, 8,  0, 1'b0, 1'b0, 6'd0,  6'd6,  1'b1, 1'b0, 1'b0};
    vectors[2] = '{0, 3'd7, 3'd7, 4,  6, 1'b0, 1'b0, 6'd0,  6'd49, 1'b1, 1'b0, 1'b0};
    vectors[3] = '{0, 3'd4, 3'd5, 10, 0, 1'b1, 1'b0, 6'd0,  6'd49, 1'b0, 1'b1, 1'b0};
    vectors[4] = '{0, 3'd3, 3'd3, 2,  0, 1'b0, 1'b0, 6'd0,  6'd9,  1'b1, 1'b0, 1'b0};
    vectors[5] = '{0, 3'd7, 3'd6, 64, 0, 1'b0, 1'b0, 6'd0,  6'd42, 1'b1, 1'b0, 1'b0};
    vectors[6] = '{0, 3'd6, 3'd4, 5,  0, 1'b0, 1'b1, 6'd25, 6'd25, 1'b1, 1'b0, 1'b1};
    vectors[7] = '{0, 3'd6, 3'd4, 5,  0, 1'b0, 1'b1, 6'd24, 6'd24, 1'b1, 1'b0, 1'b0};
    vectors[8] = '{0, 3'd0, 3'd5, 3,  0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0};
    vectors[9] = '{2, 3'd1, 3'd7, 60, 0, 1'b0, 1'b0, 6'd0,  6'd7,  1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    expectEq("reset result", 32'(result), 32'd0);
    expectEq("reset result_valid", 32'(resultValid), 32'd0);
    expectEq("reset busy", 32'(busy), 32'd0);
    expectEq("reset timeout_err", 32'(timeoutErr), 32'd0);
    expectEq("reset mul_start", 32'(mulBus.mul_start), 32'd0);
    expectEq("reset mul_a", 32'(mulBus.mul_a), 32'd0);
    expectEq("reset mul_b", 32'(mulBus.mul_b), 32'd0);
`ifdef MULT_LOADER_CHECK_EN
    expectEq("reset check_err", 32'(checkErr), 32'd0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vectors[v], v);
      checkOutput(v);
    end

    // Reset while the loader sits in WAIT; the model's late done must then be ignored.
    modelDelay    = 40;
    modelHold     = 0;
    modelNever    = 1'b0;
    modelOverride = 1'b0;
    swA           = 3'd3;
    swB           = 3'd5;
    ev0           = startEvents;
    sawStart      = 1'b0;
    fallCount     = 0;
    reached       = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      btn = btnLevel(0, i);
      if (mulBus.mul_start) sawStart = 1'b1;
      else if (sawStart) fallCount++;
      if (fallCount == 5) reached = 1'b1;
    end
    expectEq("rstwait reached WAIT", 32'(reached), 32'd1);
    expectEq("rstwait busy before rst", 32'(busy), 32'd1);
    btn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expectEq("rstwait result", 32'(result), 32'd0);
    expectEq("rstwait result_valid", 32'(resultValid), 32'd0);
    expectEq("rstwait busy", 32'(busy), 32'd0);
    expectEq("rstwait timeout_err", 32'(timeoutErr), 32'd0);
    expectEq("rstwait mul_start", 32'(mulBus.mul_start), 32'd0);
    expectEq("rstwait mul_a", 32'(mulBus.mul_a), 32'd0);
    expectEq("rstwait mul_b", 32'(mulBus.mul_b), 32'd0);
    repeat (60) @(negedge clk);
    expectEq("rstwait late busy", 32'(busy), 32'd0);
    expectEq("rstwait late result_valid", 32'(resultValid), 32'd0);
    expectEq("rstwait late result", 32'(result), 32'd0);
    expectEq("rstwait start_count", 32'(startEvents - ev0), 32'd1);
    vectorsApplied++;

    $display("[TB] %0d comparisons made", numCompares);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, numMiscompares);
    $finish;
  end

endmodule
